seq_controller: RTL and testbench

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller_if.sv | 36 +++
 rtl/seq_controller.sv | 116 +++++++++++
 tb/tb_seq_controller.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_controller_if.sv
// Control/status bundle between the Y86 sequential controller and its datapath stages.
interface seq_controller_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 start;
    logic                 step_mode;
    logic                 step;
    logic                 halt;
    logic                 invalid_instr;
    logic                 mem_error;
    logic                 dmem_error;
    logic [63:0]          PC_new;
    logic [63:0]          PC;
    logic                 fetch_en;
    logic                 decode_en;
    logic                 execute_en;
    logic                 memory_en;
    logic                 wb_en;
    logic                 pc_en;
    logic [2:0]           stat;
    logic                 busy;
    logic [CNT_WIDTH-1:0] instr_count;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, step_mode, step, halt, invalid_instr, mem_error, dmem_error, PC_new,
        input  PC, fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en, stat, busy,
               instr_count, cycle_count
    );

    modport slave (
        input  start, step_mode, step, halt, invalid_instr, mem_error, dmem_error, PC_new,
        output PC, fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en, stat, busy,
               instr_count, cycle_count
    );
endinterface

// File: rtl/seq_controller.sv
// Five-stage sequential Y86 controller with single-step, status and performance counters.
// Define INVALID_SKIP_EN to skip invalid instructions (PC+1) instead of stopping with INS.
module seq_controller #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned CNT_WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    seq_controller_if.slave bus
);
    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMemory, StPcupd, StPause, StStop
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          pc_q;
    logic [2:0]           stat_q;
    logic [CNT_WIDTH-1:0] instr_count_q, cycle_count_q;
    logic                 fetch_en_q, decode_en_q, execute_en_q, memory_en_q, wbpc_en_q;
    logic                 busy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (bus.start) state_d = StFetch;
            StFetch: begin
                if (bus.mem_error || bus.halt) begin
                    state_d = StStop;
                end else if (bus.invalid_instr) begin
`ifdef INVALID_SKIP_EN
                    state_d = StFetch;
`else
                    state_d = StStop;
`endif
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode:  state_d = StExecute;
            StExecute: state_d = StMemory;
            StMemory:  state_d = bus.dmem_error ? StStop : StPcupd;
            StPcupd:   state_d = bus.step_mode ? StPause : StFetch;
            StPause:   if (bus.step) state_d = StFetch;
            StStop:    state_d = StStop;
            default:   state_d = StIdle;
        endcase
    end

    // Enables and busy are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            stat_q        <= StatAok;
            instr_count_q <= '0;
            cycle_count_q <= '0;
            fetch_en_q    <= 1'b0;
            decode_en_q   <= 1'b0;
            execute_en_q  <= 1'b0;
            memory_en_q   <= 1'b0;
            wbpc_en_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_en_q   <= (state_d == StFetch);
            decode_en_q  <= (state_d == StDecode);
            execute_en_q <= (state_d == StExecute);
            memory_en_q  <= (state_d == StMemory);
            wbpc_en_q    <= (state_d == StPcupd);
            busy_q       <= state_d inside {StFetch, StDecode, StExecute, StMemory, StPcupd};

            if (busy_q && !(&cycle_count_q)) begin
                cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
            end

            case (state_q)
                StFetch: begin
                    if (bus.mem_error) begin
                        stat_q <= StatAdr;
                    end else if (bus.halt) begin
                        stat_q <= StatHlt;
                    end else if (bus.invalid_instr) begin
`ifdef INVALID_SKIP_EN
                        pc_q <= pc_q + 64'd1;
`else
                        stat_q <= StatIns;
`endif
                    end
                end
                StMemory: if (bus.dmem_error) stat_q <= StatAdr;
                StPcupd: begin
                    pc_q <= bus.PC_new;
                    if (!(&instr_count_q)) instr_count_q <= instr_count_q + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.PC          = pc_q;
    assign bus.stat        = stat_q;
    assign bus.fetch_en    = fetch_en_q;
    assign bus.decode_en   = decode_en_q;
    assign bus.execute_en  = execute_en_q;
    assign bus.memory_en   = memory_en_q;
    assign bus.wb_en       = wbpc_en_q;
    assign bus.pc_en       = wbpc_en_q;
    assign bus.busy        = busy_q;
    assign bus.instr_count = instr_count_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: per-cycle expectations from a stage-counter model.
module tb_seq_controller;
    localparam int unsigned CW   = 6;
    localparam int          CMAX = 63;
    localparam logic [63:0] RPC  = 64'd0;

    localparam int MIdle = 0, MRun = 1, MPause = 2, MStop = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_controller_if #(.CNT_WIDTH(CW)) bus ();

    seq_controller #(.RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  stat;
        logic [6:0]  en;   // {fetch, decode, execute, memory, wb, pc, busy}
        int          ic;
        int          cc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Next-cycle stimulus; pulses clear after each tick, step_mode and PC_new are sticky.
    logic        n_reset = 0, n_start = 0, n_step_mode = 0, n_step = 0;
    logic        n_halt = 0, n_invalid = 0, n_mem_error = 0, n_dmem_error = 0;
    logic [63:0] n_pc_new = 64'd0;

    int          m_mode = MIdle;
    int          m_stage = 0;   // 0 fetch .. 4 pc update
    logic [63:0] m_pc = RPC;
    logic [2:0]  m_stat = 3'd1;
    int          m_ic = 0, m_cc = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_mode = MIdle; m_stage = 0; m_pc = RPC; m_stat = 3'd1; m_ic = 0; m_cc = 0;
        end else begin
            case (m_mode)
                MIdle: if (bus.start) begin m_mode = MRun; m_stage = 0; end
                MRun: begin
                    m_cc = sat_inc(m_cc);
                    case (m_stage)
                        0: begin
                            if (bus.mem_error) begin m_mode = MStop; m_stat = 3'd3; end
                            else if (bus.halt) begin m_mode = MStop; m_stat = 3'd2; end
                            else if (bus.invalid_instr) begin
`ifdef INVALID_SKIP_EN
                                m_pc = m_pc + 64'd1;
`else
                                m_mode = MStop; m_stat = 3'd4;
`endif
                            end else m_stage = 1;
                        end
                        1, 2: m_stage = m_stage + 1;
                        3: begin
                            if (bus.dmem_error) begin m_mode = MStop; m_stat = 3'd3; end
                            else m_stage = 4;
                        end
                        default: begin
                            m_pc = bus.PC_new;
                            m_ic = sat_inc(m_ic);
                            if (bus.step_mode) m_mode = MPause;
                            else m_stage = 0;
                        end
                    endcase
                end
                MPause: if (bus.step) begin m_mode = MRun; m_stage = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        reset             = n_reset;
        bus.start         = n_start;
        bus.step_mode     = n_step_mode;
        bus.step          = n_step;
        bus.halt          = n_halt;
        bus.invalid_instr = n_invalid;
        bus.mem_error     = n_mem_error;
        bus.dmem_error    = n_dmem_error;
        bus.PC_new        = n_pc_new;
        model_step();
        e.pc = m_pc; e.stat = m_stat; e.ic = m_ic; e.cc = m_cc; e.en = 7'd0;
        if (m_mode == MRun) begin
            e.en[0] = 1'b1;
            if (m_stage < 4) e.en[6 - m_stage] = 1'b1;
            else e.en[2:1] = 2'b11;
        end
        sb_q.push_back(e);
        n_reset = 0; n_start = 0; n_step = 0; n_halt = 0;
        n_invalid = 0; n_mem_error = 0; n_dmem_error = 0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic restart();
        n_reset = 1; tick();
        n_start = 1; tick();
    endtask

    // Monitor: every registered update is compared against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                cmp("sb_pc", bus.PC, e.pc);
                cmp("sb_stat", 64'(bus.stat), 64'(e.stat));
                cmp("sb_enables", 64'({bus.fetch_en, bus.decode_en, bus.execute_en,
                    bus.memory_en, bus.wb_en, bus.pc_en, bus.busy}), 64'(e.en));
                cmp("sb_instr_count", 64'(bus.instr_count), 64'(e.ic));
                cmp("sb_cycle_count", 64'(bus.cycle_count), 64'(e.cc));
            end
        end
    end

    initial begin
        bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.halt = 0;
        bus.invalid_instr = 0; bus.mem_error = 0; bus.dmem_error = 0; bus.PC_new = 64'd0;

        // Reset state
        n_reset = 1; tick();
        after_edge();
        cmp("rst_pc", bus.PC, RPC);
        cmp("rst_stat", 64'(bus.stat), 64'd1);
        cmp("rst_busy", 64'(bus.busy), 64'd0);
        tick();

        // Three clean instructions
        n_start = 1; tick();
        after_edge();
        cmp("start_fetch_en", 64'(bus.fetch_en), 64'd1);
        cmp("start_pc", bus.PC, 64'd0);
        n_pc_new = 64'd2;  repeat (5) tick();
        after_edge();
        cmp("instr1_pc", bus.PC, 64'd2);
        n_pc_new = 64'd12; repeat (5) tick();
        after_edge();
        cmp("instr2_pc", bus.PC, 64'd12);
        n_pc_new = 64'd14; repeat (5) tick();
        after_edge();
        cmp("instr3_pc", bus.PC, 64'd14);
        cmp("instr3_icount", 64'(bus.instr_count), 64'd3);
        cmp("instr3_ccount", 64'(bus.cycle_count), 64'd15);
        cmp("instr3_stat", 64'(bus.stat), 64'd1);

        // Halt in 4th fetch, start ignored afterwards
        n_halt = 1; tick();
        after_edge();
        cmp("halt_stat", 64'(bus.stat), 64'd2);
        cmp("halt_icount", 64'(bus.instr_count), 64'd3);
        n_start = 1; tick(); tick();
        after_edge();
        cmp("halt_start_ignored_busy", 64'(bus.busy), 64'd0);
        cmp("halt_start_ignored_fetch", 64'(bus.fetch_en), 64'd0);

        // Invalid instruction at PC=38
        restart();
        n_pc_new = 64'd38; repeat (5) tick();
        n_invalid = 1; tick();
        after_edge();
`ifdef INVALID_SKIP_EN
        cmp("inv_pc", bus.PC, 64'd39);
        cmp("inv_fetch_en", 64'(bus.fetch_en), 64'd1);
        cmp("inv_stat", 64'(bus.stat), 64'd1);
`else
        cmp("inv_pc", bus.PC, 64'd38);
        cmp("inv_fetch_en", 64'(bus.fetch_en), 64'd0);
        cmp("inv_stat", 64'(bus.stat), 64'd4);
`endif

        // Data-memory fault, then mem_error beating halt
        restart();
        n_pc_new = 64'd77; repeat (3) tick();
        n_dmem_error = 1; tick();
        after_edge();
        cmp("dmem_stat", 64'(bus.stat), 64'd3);
        cmp("dmem_pc", bus.PC, 64'd0);
        cmp("dmem_icount", 64'(bus.instr_count), 64'd0);
        tick();
        restart();
        n_mem_error = 1; n_halt = 1; tick();
        after_edge();
        cmp("memerr_prio_stat", 64'(bus.stat), 64'd3);

        // Single-step, then reset mid-instruction
        restart();
        n_step_mode = 1; n_pc_new = 64'd100; repeat (5) tick();
        repeat (3) tick();
        after_edge();
        cmp("pause_busy", 64'(bus.busy), 64'd0);
        cmp("pause_fetch_en", 64'(bus.fetch_en), 64'd0);
        n_step = 1; tick();
        after_edge();
        cmp("step_fetch_en", 64'(bus.fetch_en), 64'd1);
        tick(); tick();
        after_edge();
        cmp("exec_en", 64'(bus.execute_en), 64'd1);
        n_reset = 1; tick();
        after_edge();
        cmp("midreset_pc", bus.PC, RPC);
        cmp("midreset_icount", 64'(bus.instr_count), 64'd0);
        cmp("midreset_ccount", 64'(bus.cycle_count), 64'd0);
        n_step_mode = 0;

        // Counter saturation
        restart();
        for (int i = 0; i < 450; i++) begin
            n_pc_new = {$urandom, $urandom};
            tick();
        end
        after_edge();
        cmp("sat_icount", 64'(bus.instr_count), 64'(CMAX));
        cmp("sat_ccount", 64'(bus.cycle_count), 64'(CMAX));

        // Randomized segments
        for (int seg = 0; seg < 6; seg++) begin
            n_step_mode = 1'($urandom_range(0, 1));
            restart();
            for (int i = 0; i < 150; i++) begin
                n_pc_new     = {$urandom, $urandom};
                n_start      = ($urandom_range(0, 4) == 0);
                n_step       = ($urandom_range(0, 2) == 0);
                n_halt       = ($urandom_range(0, 99) < 3);
                n_mem_error  = ($urandom_range(0, 99) < 2);
                n_invalid    = ($urandom_range(0, 99) < 3);
                n_dmem_error = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 15) == 0) n_step_mode = ~n_step_mode;
                n_reset      = ($urandom_range(0, 199) == 0) ||
                               (m_mode == MStop && $urandom_range(0, 7) == 0);
                tick();
            end
        end

        repeat (3) after_edge();
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
